// File: rtl/sap_pkg.sv
// Shared SAP datapath package.
// Holds the sequencing state type of the bit-serial adder/subtractor.
package sap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } serial_state_t;

endpackage

// File: rtl/fa.sv
// Gate-level one-bit full adder.
// Ports:
//   a, b  : addend bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   carry : majority(a, b, cin)
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic axb;

  assign axb   = a ^ b;
  assign sum   = axb ^ cin;
  assign carry = (a & b) | (axb & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, one result bit per clock through a single fa.
// Subtraction is A + ~B + 1, with the +1 supplied by presetting the carry flop.
// Ports:
//   CLK, CLR_N : clock, asynchronous active-low reset
//   START      : request, accepted only in IDLE
//   SUB        : 0 = A+B, 1 = A-B (sampled with START)
//   A, B       : operands (sampled with START)
//   BUSY       : bit-steps in progress
//   DONE       : one-cycle pulse, S/COUT/OVF newly valid
//   S          : result, held until the next completion
//   COUT       : carry out of the MSB (for SUB, 1 = no borrow)
//   OVF        : two's-complement overflow
//
// state | meaning
// IDLE  | waiting for START; operands loaded on acceptance
// SHIFT | one fa step per edge, LSB first, WIDTH steps
// DONE  | result valid pulse, START ignored
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF
);

  import sap_pkg::*;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  serial_state_t state, state_nxt;

  logic [WIDTH-1:0] ra, rb, res;
  logic [CNT_W-1:0] cnt;
  logic             cy;
  logic             fa_sum, fa_carry;
  logic             last_step;

  fa u_fa (
    .a     (ra[0]),
    .b     (rb[0]),
    .cin   (cy),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign last_step = (cnt == LAST_STEP);

  always_comb begin
    state_nxt = state;
    case (state)
      sap_pkg::IDLE:  if (START) state_nxt = sap_pkg::SHIFT;
      sap_pkg::SHIFT: if (last_step) state_nxt = sap_pkg::DONE;
      sap_pkg::DONE:  state_nxt = sap_pkg::IDLE;
      default:        state_nxt = sap_pkg::IDLE;
    endcase
  end

  // BUSY/DONE are flopped from the next state so they are true register outputs.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state <= sap_pkg::IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      BUSY  <= (state_nxt == sap_pkg::SHIFT);
      DONE  <= (state_nxt == sap_pkg::DONE);
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      ra   <= '0;
      rb   <= '0;
      res  <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
      S    <= '0;
      COUT <= 1'b0;
      OVF  <= 1'b0;
    end else begin
      case (state)
        sap_pkg::IDLE: begin
          if (START) begin
            ra  <= A;
            rb  <= SUB ? ~B : B;
            cy  <= SUB;
            cnt <= '0;
          end
        end
        sap_pkg::SHIFT: begin
          res <= {fa_sum, res[WIDTH-1:1]};
          ra  <= {1'b0, ra[WIDTH-1:1]};
          rb  <= {1'b0, rb[WIDTH-1:1]};
          cy  <= fa_carry;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            S    <= {fa_sum, res[WIDTH-1:1]};
            COUT <= fa_carry;
            // cy still holds the carry into the MSB on the final step
            OVF  <= fa_carry ^ cy;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  logic       clk;
  logic       clr_n;
  logic       start;
  logic       sub;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] s;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  serial_addsub #(.WIDTH(8)) dut (
    .CLK   (clk),
    .CLR_N (clr_n),
    .START (start),
    .SUB   (sub),
    .A     (a),
    .B     (b),
    .BUSY  (busy),
    .DONE  (done),
    .S     (s),
    .COUT  (cout),
    .OVF   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for DONE at negedges; returns negedges elapsed and BUSY-high count.
  task automatic wait_done(input string tag, output int n_edges, output int n_busy);
    n_edges = 0;
    n_busy  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_edges++;
      if (done) return;
      if (busy) n_busy++;
    end
    chk({tag, "_timeout"}, 0, 1);
  endtask

  // Accept one operation at the next posedge, then check latency and results.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic sv, input logic [7:0] es, input logic ec, input logic eo);
    int ne, nb;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; sub = sv;
    @(posedge clk);
    #1 start = 1'b0; a = ~av; b = ~bv; sub = ~sv;
    wait_done(tag, ne, nb);
    chk({tag, "_latency"}, ne, 9);
    chk({tag, "_busy_cycles"}, nb, 8);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_s"}, s, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    @(negedge clk);
    chk({tag, "_done_low"}, done, 0);
  endtask

  initial begin
    int ne, nb, t0, t1;
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    logic       ps [3];
    logic [7:0] pexp [3];

    clr_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s", s, 0);
    chk("rst_flags", {cout, ovf}, 0);
    clr_n = 1'b1;

    // basic add, overflow and subtract vectors
    run_op("add_5_3",   8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    run_op("add_ff_1",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_1",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub_10_3",  8'h10, 8'h03, 1'b1, 8'h0D, 1'b1, 1'b0);
    run_op("sub_3_10",  8'h03, 8'h10, 1'b1, 8'hF3, 1'b0, 1'b0);
    run_op("sub_80_1",  8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // START during BUSY (k+3) and during DONE (k+9) is ignored
    @(negedge clk);
    start = 1'b1; a = 8'h05; b = 8'h03; sub = 1'b0;
    @(posedge clk);                       // edge k
    #1 start = 1'b0;
    repeat (2) @(posedge clk);            // edge k+2
    #1 start = 1'b1; a = 8'h40; b = 8'h40;
    @(posedge clk);                       // edge k+3
    #1 start = 1'b0;
    repeat (5) @(posedge clk);            // edge k+8
    @(negedge clk);
    chk("ign_done", done, 1);
    chk("ign_s", s, 8'h08);
    start = 1'b1;
    @(posedge clk);                       // edge k+9
    #1 start = 1'b0;
    @(negedge clk);
    chk("ign_no_second_done", done, 0);
    chk("ign_idle_not_busy", busy, 0);
    start = 1'b1;
    @(posedge clk);                       // edge k+10
    #1 start = 1'b0;
    @(negedge clk);
    chk("k10_accepted_busy", busy, 1);
    wait_done("k10", ne, nb);
    chk("k10_s", s, 8'h80);
    chk("k10_flags", {cout, ovf}, 2'b01);

    // asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; a = 8'h05; b = 8'h03; sub = 1'b0;
    @(posedge clk);                       // edge k
    #1 start = 1'b0;
    repeat (4) @(posedge clk);            // edge k+4
    #2 clr_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_s", s, 0);
    chk("arst_flags", {cout, ovf}, 0);
    repeat (6) @(negedge clk);
    chk("arst_no_done", done, 0);
    clr_n = 1'b1;
    run_op("post_rst", 8'h22, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0);

    // back-to-back with START held high; operands change right after each acceptance
    pa[0] = 8'h12; pb[0] = 8'h34; ps[0] = 1'b0; pexp[0] = 8'h46;
    pa[1] = 8'h50; pb[1] = 8'h20; ps[1] = 1'b1; pexp[1] = 8'h30;
    pa[2] = 8'hC8; pb[2] = 8'h64; ps[2] = 1'b0; pexp[2] = 8'h2C;
    @(negedge clk);
    start = 1'b1; a = pa[0]; b = pb[0]; sub = ps[0];
    @(posedge clk);
    #1 a = pa[1]; b = pb[1]; sub = ps[1];
    wait_done("b2b0", ne, nb);
    chk("b2b0_s", s, pexp[0]);
    t0 = cyc;
    repeat (2) @(posedge clk);            // second acceptance edge
    #1 a = pa[2]; b = pb[2]; sub = ps[2];
    wait_done("b2b1", ne, nb);
    chk("b2b1_s", s, pexp[1]);
    chk("b2b1_cout", cout, 1);
    t1 = cyc;
    chk("b2b_period01", t1 - t0, 10);
    repeat (2) @(posedge clk);
    #1 a = 8'h00; b = 8'h00; sub = 1'b0;
    wait_done("b2b2", ne, nb);
    chk("b2b2_s", s, pexp[2]);
    chk("b2b2_flags", {cout, ovf}, 2'b10);
    chk("b2b_period12", cyc - t1, 10);
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
